// File: rtl/rx_word_assembler.sv
// rx_word_assembler: packs decoded 8b10b data symbols into BYTES-wide words.
// K symbols delimit frames. Completed words go into a first-word-fall-through
// FIFO. Saturating decoder-error and lost-word counters are kept alongside.
module rx_word_assembler #(
  parameter int         BYTES       = 3,
  parameter int         ASIZE       = 4,
  parameter int         CNT_WIDTH   = 8,
  parameter int         FLUSH_ON_K  = 0,
  parameter int         DROP_ON_ERR = 0,
  parameter logic [7:0] PAD         = 8'h00
) (
  input  logic                 WCLK,
  input  logic                 RESET_N,
  input  logic                 SYM_VALID,
  input  logic                 SYM_K,
  input  logic [7:0]           SYM_DATA,
  input  logic                 SYM_ERR,
  input  logic                 CLR_CNT,
  input  logic                 READ,
  output logic [BYTES*8-1:0]   DATA,
  output logic                 DATA_PARTIAL,
  output logic                 EMPTY,
  output logic                 FULL,
  output logic [ASIZE:0]       SIZE,
  output logic [CNT_WIDTH-1:0] DECODER_ERR_CNT,
  output logic [CNT_WIDTH-1:0] LOST_ERR_CNT
);

  localparam int SEL_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int WORD_W = BYTES * 8;
  localparam int DEPTH  = 1 << ASIZE;
  localparam logic [SEL_W-1:0] LAST_SEL  = SEL_W'(BYTES - 1);
  localparam logic [ASIZE:0]   DEPTH_CNT = (ASIZE + 1)'(DEPTH);

  // Assembler state
  logic [SEL_W-1:0]  byte_sel_reg;
  logic [WORD_W-1:0] word_reg;
  logic [WORD_W-1:0] store_word;
  logic [WORD_W-1:0] flush_word;
  logic              wr_req_reg;
  logic              wr_partial_reg;
  logic [WORD_W-1:0] wr_word_reg;

  // FIFO state
  logic [WORD_W:0]   mem [DEPTH];
  logic [ASIZE-1:0]  wr_ptr_reg;
  logic [ASIZE-1:0]  rd_ptr_reg;
  logic [ASIZE:0]    size_reg;
  logic [ASIZE:0]    size_next;
  logic              empty_reg;
  logic              full_reg;
  logic              wr_en;
  logic              rd_en;
  logic [WORD_W:0]   head;

  // Counters
  logic [CNT_WIDTH-1:0] dec_cnt_reg;
  logic [CNT_WIDTH-1:0] lost_cnt_reg;

  // store_word: buffer with the incoming byte merged at byte_sel.
  // flush_word: received positions kept, the rest replaced with PAD.
  // Position 0 (first received byte) lands in the MSBs.
  generate
    for (genvar gi = 0; gi < BYTES; gi++) begin : g_pos
      assign store_word[(BYTES-gi)*8-1 -: 8] =
        (byte_sel_reg == SEL_W'(gi)) ? SYM_DATA : word_reg[(BYTES-gi)*8-1 -: 8];
      assign flush_word[(BYTES-gi)*8-1 -: 8] =
        (SEL_W'(gi) < byte_sel_reg) ? word_reg[(BYTES-gi)*8-1 -: 8] : PAD;
    end
  endgenerate

  // Symbol assembly: track byte position and raise a one-cycle write request.
  always_ff @(posedge WCLK) begin
    if (!RESET_N) begin
      byte_sel_reg   <= '0;
      word_reg       <= '0;
      wr_req_reg     <= 1'b0;
      wr_partial_reg <= 1'b0;
      wr_word_reg    <= '0;
    end else begin
      wr_req_reg <= 1'b0;
      if (SYM_VALID) begin
        if (SYM_ERR && (DROP_ON_ERR != 0)) begin
          // Erroneous symbol throws away the partial word, never flushes.
          byte_sel_reg <= '0;
        end else if (SYM_K) begin
          byte_sel_reg <= '0;
          if ((FLUSH_ON_K != 0) && (byte_sel_reg != '0)) begin
            wr_req_reg     <= 1'b1;
            wr_word_reg    <= flush_word;
            wr_partial_reg <= 1'b1;
          end
        end else begin
          word_reg <= store_word;
          if (byte_sel_reg == LAST_SEL) begin
            byte_sel_reg   <= '0;
            wr_req_reg     <= 1'b1;
            wr_word_reg    <= store_word;
            wr_partial_reg <= 1'b0;
          end else begin
            byte_sel_reg <= byte_sel_reg + SEL_W'(1);
          end
        end
      end
    end
  end

  assign wr_en = wr_req_reg && !full_reg;
  assign rd_en = READ && !empty_reg;

  // Occupancy for the next cycle; write and read together cancel out.
  always_comb begin
    size_next = size_reg;
    if (wr_en && !rd_en) begin
      size_next = size_reg + (ASIZE + 1)'(1);
    end else if (rd_en && !wr_en) begin
      size_next = size_reg - (ASIZE + 1)'(1);
    end
  end

  // FIFO pointers and registered status flags.
  always_ff @(posedge WCLK) begin
    if (!RESET_N) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      size_reg   <= '0;
      empty_reg  <= 1'b1;
      full_reg   <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + ASIZE'(1);
      if (rd_en) rd_ptr_reg <= rd_ptr_reg + ASIZE'(1);
      size_reg  <= size_next;
      empty_reg <= (size_next == '0);
      full_reg  <= (size_next == DEPTH_CNT);
    end
  end

  // FIFO storage: partial flag kept in the top bit of each entry.
  always_ff @(posedge WCLK) begin
    if (RESET_N && wr_en) begin
      mem[wr_ptr_reg] <= {wr_partial_reg, wr_word_reg};
    end
  end

  // Saturating counters; clear takes priority over any increment.
  always_ff @(posedge WCLK) begin
    if (!RESET_N || CLR_CNT) begin
      dec_cnt_reg  <= '0;
      lost_cnt_reg <= '0;
    end else begin
      if (SYM_VALID && SYM_ERR && (dec_cnt_reg != '1)) begin
        dec_cnt_reg <= dec_cnt_reg + CNT_WIDTH'(1);
      end
      if (wr_req_reg && full_reg && (lost_cnt_reg != '1)) begin
        lost_cnt_reg <= lost_cnt_reg + CNT_WIDTH'(1);
      end
    end
  end

  // Fall-through head; outputs forced to zero while empty.
  assign head            = mem[rd_ptr_reg];
  assign DATA            = empty_reg ? '0 : head[WORD_W-1:0];
  assign DATA_PARTIAL    = !empty_reg && head[WORD_W];
  assign EMPTY           = empty_reg;
  assign FULL            = full_reg;
  assign SIZE            = size_reg;
  assign DECODER_ERR_CNT = dec_cnt_reg;
  assign LOST_ERR_CNT    = lost_cnt_reg;

endmodule

// File: tb/tb_rx_word_assembler.sv
// Bench for rx_word_assembler: instance A uses defaults, instance B uses
// ASIZE=2, FLUSH_ON_K=1, DROP_ON_ERR=1, PAD=8'hEE. Expected words are queued
// by the stimulus process and popped by per-instance monitors on reads.
module tb_rx_word_assembler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A signals
  logic        a_rst_n, a_valid, a_k, a_err, a_clr, a_read;
  logic [7:0]  a_sym;
  logic [23:0] a_data;
  logic        a_partial, a_empty, a_full;
  logic [4:0]  a_size;
  logic [7:0]  a_dec, a_lost;

  // Instance B signals
  logic        b_rst_n, b_valid, b_k, b_err, b_clr, b_read;
  logic [7:0]  b_sym;
  logic [23:0] b_data;
  logic        b_partial, b_empty, b_full;
  logic [2:0]  b_size;
  logic [7:0]  b_dec, b_lost;

  int vectors = 0;
  int miscompares = 0;

  logic [24:0] qa[$];
  logic [24:0] qb[$];
  logic [24:0] exp_a, exp_b;

  rx_word_assembler u_a (
    .WCLK(clk), .RESET_N(a_rst_n), .SYM_VALID(a_valid), .SYM_K(a_k),
    .SYM_DATA(a_sym), .SYM_ERR(a_err), .CLR_CNT(a_clr), .READ(a_read),
    .DATA(a_data), .DATA_PARTIAL(a_partial), .EMPTY(a_empty), .FULL(a_full),
    .SIZE(a_size), .DECODER_ERR_CNT(a_dec), .LOST_ERR_CNT(a_lost)
  );

  rx_word_assembler #(
    .BYTES(3), .ASIZE(2), .CNT_WIDTH(8), .FLUSH_ON_K(1), .DROP_ON_ERR(1), .PAD(8'hEE)
  ) u_b (
    .WCLK(clk), .RESET_N(b_rst_n), .SYM_VALID(b_valid), .SYM_K(b_k),
    .SYM_DATA(b_sym), .SYM_ERR(b_err), .CLR_CNT(b_clr), .READ(b_read),
    .DATA(b_data), .DATA_PARTIAL(b_partial), .EMPTY(b_empty), .FULL(b_full),
    .SIZE(b_size), .DECODER_ERR_CNT(b_dec), .LOST_ERR_CNT(b_lost)
  );

  // Monitor A: compare the head word against the scoreboard on each accepted read
  always @(negedge clk) begin
    if (a_read && !a_empty) begin
      vectors++;
      if (qa.size() == 0) begin
        miscompares++;
        $display("FAIL a_pop: got %h/%0d, required no word", a_data, a_partial);
      end else begin
        exp_a = qa.pop_front();
        if ({a_partial, a_data} !== exp_a) begin
          miscompares++;
          $display("FAIL a_pop: got data=%h partial=%0d, required data=%h partial=%0d",
                   a_data, a_partial, exp_a[23:0], exp_a[24]);
        end else begin
          $display("a_pop: data=%h partial=%0d ok", a_data, a_partial);
        end
      end
    end
  end

  // Monitor B
  always @(negedge clk) begin
    if (b_read && !b_empty) begin
      vectors++;
      if (qb.size() == 0) begin
        miscompares++;
        $display("FAIL b_pop: got %h/%0d, required no word", b_data, b_partial);
      end else begin
        exp_b = qb.pop_front();
        if ({b_partial, b_data} !== exp_b) begin
          miscompares++;
          $display("FAIL b_pop: got data=%h partial=%0d, required data=%h partial=%0d",
                   b_data, b_partial, exp_b[23:0], exp_b[24]);
        end else begin
          $display("b_pop: data=%h partial=%0d ok", b_data, b_partial);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end else begin
      $display("%s: %0h ok", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one symbol to instance u for one cycle
  task automatic sym(input int u, input logic k, input logic [7:0] d, input logic e);
    a_valid = 1'b0;
    b_valid = 1'b0;
    if (u == 0) begin
      a_valid = 1'b1; a_k = k; a_sym = d; a_err = e;
    end else begin
      b_valid = 1'b1; b_k = k; b_sym = d; b_err = e;
    end
    tick();
  endtask

  task automatic idle(input int n);
    a_valid = 1'b0;
    b_valid = 1'b0;
    a_err = 1'b0;
    b_err = 1'b0;
    repeat (n) tick();
  endtask

  task automatic pop(input int u, input int n);
    if (u == 0) a_read = 1'b1; else b_read = 1'b1;
    repeat (n) tick();
    a_read = 1'b0;
    b_read = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    a_rst_n = 1'b0; a_valid = 1'b0; a_k = 1'b0; a_sym = 8'h00; a_err = 1'b0;
    a_clr = 1'b0; a_read = 1'b0;
    b_rst_n = 1'b0; b_valid = 1'b0; b_k = 1'b0; b_sym = 8'h00; b_err = 1'b0;
    b_clr = 1'b0; b_read = 1'b0;
    repeat (3) tick();
    a_rst_n = 1'b1;
    b_rst_n = 1'b1;
    tick();

    // Reset state
    check("a_reset_empty", 32'(a_empty), 32'd1);
    check("a_reset_size", 32'(a_size), 32'd0);
    check("a_reset_data", 32'(a_data), 32'd0);
    check("b_reset_full", 32'(b_full), 32'd0);

    // A: K28.5 then six data bytes -> two words, latency 2 edges
    sym(0, 1'b1, 8'hBC, 1'b0);
    sym(0, 1'b0, 8'h11, 1'b0);
    sym(0, 1'b0, 8'h22, 1'b0);
    sym(0, 1'b0, 8'h33, 1'b0);
    qa.push_back({1'b0, 24'h112233});
    check("a_empty_after_edge_n", 32'(a_empty), 32'd1);
    sym(0, 1'b0, 8'h44, 1'b0);
    check("a_empty_after_edge_n1", 32'(a_empty), 32'd0);
    sym(0, 1'b0, 8'h55, 1'b0);
    sym(0, 1'b0, 8'h66, 1'b0);
    qa.push_back({1'b0, 24'h445566});
    idle(2);
    check("a_size_two", 32'(a_size), 32'd2);
    pop(0, 2);
    check("a_empty_after_pops", 32'(a_empty), 32'd1);
    check("a_data_forced_zero", 32'(a_data), 32'd0);

    // A: FLUSH_ON_K=0 -> partial discarded silently
    sym(0, 1'b0, 8'hAA, 1'b0);
    sym(0, 1'b1, 8'hBC, 1'b0);
    idle(3);
    check("a_no_flush_size", 32'(a_size), 32'd0);

    // A: DROP_ON_ERR=0 -> erroneous byte stored normally
    sym(0, 1'b0, 8'h01, 1'b0);
    sym(0, 1'b0, 8'h02, 1'b1);
    sym(0, 1'b0, 8'h03, 1'b0);
    qa.push_back({1'b0, 24'h010203});
    idle(2);
    check("a_dec_cnt_one", 32'(a_dec), 32'd1);
    pop(0, 1);

    // A: 300 erroneous K symbols saturate the decoder counter
    for (int i = 0; i < 300; i++) sym(0, 1'b1, 8'hBC, 1'b1);
    idle(1);
    check("a_dec_saturated", 32'(a_dec), 32'd255);
    a_clr = 1'b1;
    sym(0, 1'b1, 8'hBC, 1'b1);
    a_clr = 1'b0;
    idle(1);
    check("a_dec_cleared", 32'(a_dec), 32'd0);

    // A: reset mid-word with three words queued
    sym(0, 1'b1, 8'hBC, 1'b1);
    for (int w = 0; w < 3; w++) begin
      for (int b = 0; b < 3; b++) sym(0, 1'b0, 8'(8'h20 + 3 * w + b), 1'b0);
    end
    sym(0, 1'b0, 8'h77, 1'b0);
    sym(0, 1'b0, 8'h88, 1'b0);
    idle(1);
    check("a_pre_reset_size", 32'(a_size), 32'd3);
    check("a_pre_reset_dec", 32'(a_dec), 32'd1);
    a_rst_n = 1'b0;
    tick();
    a_rst_n = 1'b1;
    check("a_post_reset_empty", 32'(a_empty), 32'd1);
    check("a_post_reset_size", 32'(a_size), 32'd0);
    check("a_post_reset_full", 32'(a_full), 32'd0);
    check("a_post_reset_dec", 32'(a_dec), 32'd0);
    check("a_post_reset_lost", 32'(a_lost), 32'd0);
    check("a_post_reset_data", 32'(a_data), 32'd0);
    sym(0, 1'b0, 8'h0A, 1'b0);
    sym(0, 1'b0, 8'h0B, 1'b0);
    sym(0, 1'b0, 8'h0C, 1'b0);
    qa.push_back({1'b0, 24'h0A0B0C});
    idle(2);
    check("a_post_reset_one_word", 32'(a_size), 32'd1);
    pop(0, 1);

    // B: FLUSH_ON_K=1 -> padded partial word
    sym(1, 1'b0, 8'hAA, 1'b0);
    sym(1, 1'b1, 8'hBC, 1'b0);
    qb.push_back({1'b1, 24'hAAEEEE});
    idle(2);
    check("b_flush_size", 32'(b_size), 32'd1);
    pop(1, 1);

    // B: DROP_ON_ERR=1 -> partial discarded at error
    sym(1, 1'b0, 8'h01, 1'b0);
    sym(1, 1'b0, 8'h02, 1'b1);
    sym(1, 1'b0, 8'h03, 1'b0);
    sym(1, 1'b0, 8'h04, 1'b0);
    sym(1, 1'b0, 8'h05, 1'b0);
    qb.push_back({1'b0, 24'h030405});
    idle(2);
    check("b_dec_cnt_one", 32'(b_dec), 32'd1);
    check("b_drop_size", 32'(b_size), 32'd1);
    pop(1, 1);

    // B: six words into a depth-4 FIFO -> two lost
    for (int w = 0; w < 6; w++) begin
      for (int b = 0; b < 3; b++) sym(1, 1'b0, 8'(8'h40 + 3 * w + b), 1'b0);
    end
    qb.push_back({1'b0, 24'h404142});
    qb.push_back({1'b0, 24'h434445});
    qb.push_back({1'b0, 24'h464748});
    qb.push_back({1'b0, 24'h494A4B});
    idle(2);
    check("b_full", 32'(b_full), 32'd1);
    check("b_size_full", 32'(b_size), 32'd4);
    check("b_lost_two", 32'(b_lost), 32'd2);
    pop(1, 4);
    check("b_empty_after_pops", 32'(b_empty), 32'd1);
    check("b_data_forced_zero", 32'(b_data), 32'd0);
    check("b_partial_forced_zero", 32'(b_partial), 32'd0);
    pop(1, 2);
    check("b_no_underflow", 32'(b_size), 32'd0);

    idle(2);
    check("a_scoreboard_drained", 32'(qa.size()), 32'd0);
    check("b_scoreboard_drained", 32'(qb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rx_word_assembler.md
# rx_word_assembler

Parametrised successor to the fixed 3-byte FE-I4 record assembler. It takes decoded 8b10b symbols (K flag, 8-bit data, error flag) in the WCLK domain and packs BYTES data symbols into one word. K symbols act as frame delimiters. Completed words are buffered in an internal first-word-fall-through FIFO, and saturating decoder-error and lost-word counters are kept alongside. It sits between the 8b10b decoder and the clock-domain-crossing FIFO of a receiver channel.

## Interface
Parameters:
- BYTES, 3: data bytes per output word, legal range 2..8.
- ASIZE, 4: FIFO address width; depth is 2**ASIZE words.
- CNT_WIDTH, 8: width of the error counters.
- FLUSH_ON_K, 0: 1 means a K symbol arriving mid-word emits the padded partial word.
- DROP_ON_ERR, 0: 1 means an erroneous symbol discards the partial word.
- PAD, 8'h00: fill byte for unreceived positions of a flushed partial word.

Ports:
- WCLK  in  1  the single clock. Everything is posedge WCLK.
- RESET_N  in  1  synchronous, active-low reset.
- SYM_VALID  in  1  decoded symbol present this cycle.
- SYM_K  in  1  symbol is a control (K) character.
- SYM_DATA  in  8  decoded data byte.
- SYM_ERR  in  1  code or disparity error on this symbol.
- CLR_CNT  in  1  synchronous clear of both counters.
- READ  in  1  pop the FIFO head.
- DATA  out  BYTES*8  FIFO head word. First received byte sits in the MSBs.
- DATA_PARTIAL  out  1  head word was flushed by a K symbol.
- EMPTY  out  1  FIFO empty.
- FULL  out  1  FIFO holds 2**ASIZE words.
- SIZE  out  ASIZE+1  current word count.
- DECODER_ERR_CNT  out  CNT_WIDTH  saturating count of erroneous symbols.
- LOST_ERR_CNT  out  CNT_WIDTH  saturating count of words dropped because the FIFO was full.

## Operation
Only cycles with SYM_VALID=1 are evaluated; all other cycles leave the assembler state unchanged.

Byte pointer:
- byte_sel runs 0..BYTES-1.
- A data symbol (SYM_K=0) is stored at position byte_sel, occupying bits [(BYTES-byte_sel)*8-1 -: 8].

Word completion:
- A data symbol stored at byte_sel=BYTES-1 completes the word.
- byte_sel returns to 0 and a write request (wr_req) is registered for the next cycle with partial=0.

K symbol:
- byte_sel returns to 0 and the K symbol is never stored.
- If FLUSH_ON_K=1 and byte_sel≠0, wr_req is raised with partial=1. Positions byte_sel..BYTES-1 are filled with PAD.
- If FLUSH_ON_K=0, the partial bytes are discarded silently.

Erroneous symbol (SYM_ERR=1):
- DECODER_ERR_CNT increments, saturating at all-ones.
- If DROP_ON_ERR=1, the symbol is not stored, byte_sel returns to 0 and the partial word is discarded. No flush occurs, even for a K symbol.
- If DROP_ON_ERR=0, the symbol is processed normally.

FIFO write:
- When wr_req=1 and FULL=0, the word is written.
- When wr_req=1 and FULL=1, the word is dropped and LOST_ERR_CNT increments, saturating. This holds even if READ pops in the same cycle; FULL is evaluated pre-edge.

FIFO read:
- READ with EMPTY=0 advances the head.
- READ with EMPTY=1 is ignored; SIZE never underflows.
- A simultaneous accepted write and read leaves SIZE unchanged.

Output forcing: DATA and DATA_PARTIAL are forced to 0 while EMPTY=1.

Counters:
- CLR_CNT=1 zeroes both counters.
- CLR_CNT wins over a coincident increment.

Reset: the FIFO pointers and byte_sel wrap modulo their range. RESET_N=0 at an edge, including mid-word or mid-write, produces the following state after that edge:
- byte_sel=0 and wr_req=0.
- FIFO empty: EMPTY=1, FULL=0, SIZE=0, DATA=0, DATA_PARTIAL=0.
- Both counters 0.
- Any pending wr_req is discarded and not counted as lost.

## Timing
- Last symbol of a word sampled at edge n sets wr_req after edge n.
- The FIFO write happens at edge n+1; EMPTY falls and DATA is valid after edge n+1. Latency is 2 edges.
- FWFT: DATA and DATA_PARTIAL are valid combinationally from registered state in any cycle with EMPTY=0.
- READ at edge m presents the next word, or EMPTY=1, after edge m.
- FULL, EMPTY and SIZE are registered and update after the edge that changes occupancy.
- Counter increments are visible after the edge following the cause:
  - edge n for DECODER_ERR_CNT, where n samples the erroneous symbol;
  - edge n+1 for LOST_ERR_CNT, where n+1 is the blocked write.
- Back-to-back symbols every cycle are sustained with no bubbles: one word per BYTES cycles.

## Test plan
- Defaults; stream K28.5, then data 0x11, 0x22, 0x33, 0x44, 0x55, 0x66 on consecutive cycles -> two words 0x112233 and 0x445566, each with DATA_PARTIAL=0. EMPTY falls 2 edges after 0x33 is sampled; SIZE=2.
- FLUSH_ON_K=1, PAD=8'hEE; send data 0xAA, then K -> word 0xAAEEEE with DATA_PARTIAL=1. With FLUSH_ON_K=0 -> nothing written.
- DROP_ON_ERR=1; send 0x01, then 0x02 with SYM_ERR=1, then 0x03, 0x04, 0x05 -> single word 0x030405 and DECODER_ERR_CNT=1. With DROP_ON_ERR=0 -> word 0x010203, DECODER_ERR_CNT=1.
- ASIZE=2, READ held 0; write 6 words -> FULL=1, SIZE=4, LOST_ERR_CNT=2. Then pop 4 words -> first 4 words in order, EMPTY=1, DATA=0. READ while empty leaves SIZE=0.
- CNT_WIDTH=8; inject 300 SYM_ERR symbols -> DECODER_ERR_CNT=255. Assert CLR_CNT together with one more error -> counter reads 0.
- RESET_N=0 for one cycle after 2 of 3 bytes, with 3 words queued -> EMPTY=1, SIZE=0, counters 0. A following full 3-byte sequence yields exactly one correct word.
